// File: rtl/fns_seq_encoder.sv
// fns_seq_encoder: greedy FNS encoder, one TSV per clock MSB first; faulty/unused TSVs stay 0.
// Optional adjacency checker enabled by defining FNS_ENC_ADJ_CHECK_EN.
module fns_seq_encoder #(
    parameter int N  = 9,
    parameter int DW = 6,
    parameter int WW = 7
) (
    input  logic            clk,
    input  logic            rst,
    input  logic [N-1:0]    en_flag,
    input  logic [N*WW-1:0] weights,
    input  logic [DW-1:0]   in_data,
    input  logic            in_valid,
    output logic            in_ready,
    output logic [N-1:0]    code,
    output logic            overflow,
    output logic            code_err,
    output logic            out_valid,
    input  logic            out_ready
);
    localparam int IW = $clog2(N);
    typedef enum logic [1:0] {IDLE, ENC, DONE} state_t;
    state_t state, state_n;
    logic [N-1:0] code_q, code_n, en_q, en_n;
    logic [N*WW-1:0] w_q, w_n;
    logic [WW:0] res_q, res_n, w_i;
    logic [IW-1:0] idx_q, idx_n;
    logic ovf_q, ovf_n, sel;
    assign w_i = {1'b0, w_q[int'(idx_q)*WW +: WW]};
    // zero weight never selects, so a disabled-by-weight position cannot eat residue
    assign sel = en_q[idx_q] && (w_i != '0) && (res_q >= w_i);
    assign in_ready = (state == IDLE);
    assign out_valid = (state == DONE);
    assign code = code_q;
    assign overflow = ovf_q;
`ifdef FNS_ENC_ADJ_CHECK_EN
    logic err_q, err_n, last_q, last_n;
    assign code_err = err_q;
`else
    assign code_err = 1'b0;
`endif
    always_comb begin
        state_n = state;
        code_n = code_q;
        en_n = en_q;
        w_n = w_q;
        res_n = res_q;
        idx_n = idx_q;
        ovf_n = ovf_q;
`ifdef FNS_ENC_ADJ_CHECK_EN
        err_n = err_q;
        last_n = last_q;
`endif
        unique case (state)
            IDLE: if (in_valid) begin
                res_n = (WW+1)'(in_data);
                en_n = en_flag;
                w_n = weights;
                code_n = '0;
                idx_n = IW'(N-1);
                ovf_n = 1'b0;
`ifdef FNS_ENC_ADJ_CHECK_EN
                err_n = 1'b0;
                last_n = 1'b0;
`endif
                state_n = ENC;
            end
            ENC: begin
                code_n[idx_q] = sel;
                res_n = sel ? res_q - w_i : res_q;
`ifdef FNS_ENC_ADJ_CHECK_EN
                // adjacency is judged only between enabled neighbours, skipping faulty TSVs
                if (en_q[idx_q]) begin
                    err_n = err_q | (sel & last_q);
                    last_n = sel;
                end
`endif
                if (idx_q == '0) begin
                    ovf_n = (res_n != '0);
                    state_n = DONE;
                end else begin
                    idx_n = idx_q - 1'b1;
                end
            end
            DONE: state_n = out_ready ? IDLE : DONE;
            default: state_n = IDLE;
        endcase
    end
    always_ff @(posedge clk) begin
        if (rst) begin
            state <= IDLE;
            code_q <= '0;
            en_q <= '0;
            w_q <= '0;
            res_q <= '0;
            idx_q <= IW'(N-1);
            ovf_q <= 1'b0;
`ifdef FNS_ENC_ADJ_CHECK_EN
            err_q <= 1'b0;
            last_q <= 1'b0;
`endif
        end else begin
            state <= state_n;
            code_q <= code_n;
            en_q <= en_n;
            w_q <= w_n;
            res_q <= res_n;
            idx_q <= idx_n;
            ovf_q <= ovf_n;
`ifdef FNS_ENC_ADJ_CHECK_EN
            err_q <= err_n;
            last_q <= last_n;
`endif
        end
    end
endmodule

// File: tb/tb_fns_seq_encoder.sv
// tb_fns_seq_encoder: random and directed stimulus checked against a greedy FNS model.
module tb_fns_seq_encoder;
    localparam int N = 9, DW = 6, WW = 7;
`ifdef FNS_ENC_ADJ_CHECK_EN
    localparam bit ADJ = 1'b1;
`else
    localparam bit ADJ = 1'b0;
`endif
    logic clk = 1'b0, rst = 1'b1;
    logic [N-1:0] en_flag = '0, code;
    logic [N*WW-1:0] weights = '0;
    logic [DW-1:0] in_data = '0;
    logic in_valid = 1'b0, out_ready = 1'b0;
    logic in_ready, overflow, code_err, out_valid;
    int checks = 0, failures = 0;
    typedef struct packed {logic [N-1:0] c; logic o; logic e;} res_t;
    res_t exp_q[$];
    fns_seq_encoder #(.N(N), .DW(DW), .WW(WW)) dut (
        .clk(clk), .rst(rst), .en_flag(en_flag), .weights(weights), .in_data(in_data),
        .in_valid(in_valid), .in_ready(in_ready), .code(code), .overflow(overflow),
        .code_err(code_err), .out_valid(out_valid), .out_ready(out_ready)
    );
    always #5 clk = ~clk;
    task automatic chk(input string name, input logic [31:0] act, input logic [31:0] req);
        checks++;
        if (act !== req) begin
            failures++;
            $display("FAIL %s actual=%0h required=%0h", name, act, req);
        end
    endtask
    // Zeckendorf-style greedy pick, then adjacency judged on the list of enabled bits
    function automatic res_t model(input logic [DW-1:0] d, input logic [N-1:0] en, input logic [N*WW-1:0] w);
        res_t r;
        int rem;
        bit seq[$];
        r = '0;
        rem = int'(d);
        for (int i = N-1; i >= 0; i--) begin
            int wi;
            wi = int'(w[i*WW +: WW]);
            if (en[i] && wi > 0 && rem >= wi) begin
                r.c[i] = 1'b1;
                rem -= wi;
            end
            if (en[i]) seq.push_back(r.c[i]);
        end
        r.o = (rem != 0);
        for (int k = 1; k < seq.size(); k++) if (seq[k] && seq[k-1]) r.e = 1'b1;
        if (!ADJ) r.e = 1'b0;
        return r;
    endfunction
    function automatic logic [N*WW-1:0] pack(input int a[N]);
        logic [N*WW-1:0] v;
        for (int i = 0; i < N; i++) v[i*WW +: WW] = WW'(a[i]);
        return v;
    endfunction
    always @(negedge clk) if (!rst && out_valid) begin
        if (exp_q.size() == 0) begin
            checks++;
            failures++;
            $display("FAIL unexpected_out_valid actual=1 required=0");
        end else begin
            chk("code", code, exp_q[0].c);
            chk("overflow", overflow, exp_q[0].o);
            chk("code_err", code_err, exp_q[0].e);
        end
    end
    always @(posedge clk) if (!rst && out_valid && out_ready && exp_q.size() > 0) void'(exp_q.pop_front());
    task automatic send(input logic [DW-1:0] d, input logic [N-1:0] en, input logic [N*WW-1:0] w);
        int t = 0;
        while (!in_ready && t < 50) begin
            @(negedge clk);
            t++;
        end
        chk("in_ready_wait", in_ready, 1);
        in_data = d;
        en_flag = en;
        weights = w;
        in_valid = 1'b1;
        @(posedge clk);
        exp_q.push_back(model(d, en, w));
        @(negedge clk);
        in_valid = 1'b0;
        in_data = DW'($urandom);
        en_flag = N'($urandom);
        weights = {$urandom, $urandom};
        chk("in_ready_busy", in_ready, 0);
    endtask
    task automatic finish_word(input int hold, input bit poke);
        int lat = 1;
        while (!out_valid && lat <= 50) begin
            @(negedge clk);
            lat++;
        end
        chk("latency", lat, N+1);
        if (!out_valid) return;
        repeat (hold) begin
            chk("in_ready_done", in_ready, 0);
            chk("out_valid_hold", out_valid, 1);
            in_valid = poke;
            in_data = DW'($urandom);
            @(negedge clk);
        end
        in_valid = 1'b0;
        out_ready = 1'b1;
        @(negedge clk);
        out_ready = 1'b0;
        chk("out_valid_release", out_valid, 0);
        chk("in_ready_release", in_ready, 1);
    endtask
    initial begin
        int fw[N] = '{1, 2, 3, 5, 8, 13, 21, 34, 55};
        int w2[N] = '{1, 2, 0, 3, 5, 8, 13, 21, 34};
        int w3[N] = '{1, 2, 3, 0, 0, 0, 0, 0, 0};
        res_t r;
        repeat (3) @(negedge clk);
        chk("rst_in_ready", in_ready, 1);
        chk("rst_out_valid", out_valid, 0);
        chk("rst_code", code, 0);
        chk("rst_overflow", overflow, 0);
        chk("rst_code_err", code_err, 0);
        rst = 1'b0;
        @(negedge clk);
        r = model(6'd20, 9'h1FF, pack(fw));
        chk("pin1_code", r.c, 9'h02A);
        chk("pin1_ovf", r.o, 0);
        chk("pin1_err", r.e, 0);
        send(6'd20, 9'h1FF, pack(fw));
        finish_word(0, 1'b0);
        r = model(6'd20, 9'h1FB, pack(w2));
        chk("pin2_code", r.c, 9'h052);
        chk("pin2_ovf", r.o, 0);
        send(6'd20, 9'h1FB, pack(w2));
        finish_word(1, 1'b0);
        r = model(6'd7, 9'h007, pack(w3));
        chk("pin3_code", r.c, 9'h007);
        chk("pin3_ovf", r.o, 1);
        chk("pin3_err", r.e, ADJ);
        send(6'd7, 9'h007, pack(w3));
        finish_word(5, 1'b1);
        send(6'd33, 9'h1FF, pack(fw));
        finish_word(0, 1'b0);
        send(6'd45, 9'h1FF, pack(fw));
        repeat (4) @(negedge clk);
        rst = 1'b1;
        @(negedge clk);
        exp_q.delete();
        chk("midrst_out_valid", out_valid, 0);
        chk("midrst_in_ready", in_ready, 1);
        chk("midrst_code", code, 0);
        in_valid = 1'b1;
        in_data = 6'd63;
        @(negedge clk);
        rst = 1'b0;
        in_valid = 1'b0;
        chk("rst_vs_valid_in_ready", in_ready, 1);
        r = model(6'd0, 9'h1FF, pack(fw));
        chk("pin4_code", r.c, 0);
        chk("pin4_ovf", r.o, 0);
        send(6'd0, 9'h1FF, pack(fw));
        finish_word(2, 1'b0);
        for (int n = 0; n < 30; n++) begin
            logic [N-1:0] en;
            logic [N*WW-1:0] w;
            int k;
            en = N'($urandom);
            if ($urandom_range(0, 1) == 1) begin
                k = 0;
                w = '0;
                for (int i = 0; i < N; i++) if (en[i]) begin
                    w[i*WW +: WW] = WW'(fw[k]);
                    k++;
                end
            end else begin
                w = {$urandom, $urandom, $urandom};
            end
            send(DW'($urandom), en, w);
            finish_word($urandom_range(0, 3), n[0]);
        end
        repeat (2) @(negedge clk);
        chk("queue_drained", exp_q.size(), 0);
        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end
endmodule

// File: doc/fns_seq_encoder.md
Name: fns_seq_encoder

Overview:
- Sequential Fibonacci-number-system (FNS) data encoder.
- Sits directly downstream of the FNS adder chain for a 6+3 TSV group. It consumes that chain's per-TSV enable flags and per-TSV FNS weights.
- Converts each binary data word into a crosstalk-avoidance codeword over the healthy TSVs. Uses greedy (Zeckendorf) decomposition, one TSV position per clock, MSB first.
- Faulty and unused redundant TSVs are always driven 0.

Parameters:
- N, 9, number of TSV positions (x+y).
- DW, 6, data word width.
- WW, 7, width of each per-TSV weight.

Ports:
- clk  input  1  system clock.
- rst  input  1  synchronous, active-high reset.
- en_flag  input  N  per-TSV enable; bit 0 = first TSV.
- weights  input  N*WW  flattened weights; weights[i*WW +: WW] is the weight of TSV i.
- in_data  input  DW  binary word to encode.
- in_valid  input  1  in_data/en_flag/weights valid.
- in_ready  output  1  block can accept a word.
- code  output  N  encoded TSV word; bit i drives TSV i.
- overflow  output  1  residue nonzero after the last position; code is incomplete.
- code_err  output  1  adjacency violation (see Optional Feature).
- out_valid  output  1  code/overflow/code_err valid.
- out_ready  input  1  consumer accepts result.

Behaviour:
- Interface: one clock; reset is synchronous and active-high (ports clk, rst).
- States: IDLE, ENC, DONE.
- Reset values: state=IDLE, code=0, overflow=0, code_err=0, out_valid=0, in_ready=1, residue=0, index=N-1.
- IDLE:
  - in_ready=1.
  - On in_valid, capture in_data into residue (zero-extended to WW+1 bits), en_flag and weights into local registers; clear the code register; set index=N-1; go to ENC.
  - en_flag and weights are sampled only at acceptance. Later changes do not affect the word in flight.
- ENC, one position per cycle, i=index:
  - If en_flag_q[i]=1 and residue >= w_q[i]: code[i]=1 and residue -= w_q[i].
  - Else code[i]=0.
  - A weight of 0 on an enabled position is treated as never-select (bit 0).
  - If i=0: overflow = (residue after this step != 0); go to DONE. Else index decrements.
  - in_ready=0 throughout ENC and DONE.
- DONE:
  - out_valid=1; code, overflow and code_err are held stable.
  - On out_ready=1, go to IDLE with out_valid=0. in_ready returns to 1 on the following cycle; no same-cycle accept-and-release.
  - If out_ready stays 0, hold indefinitely (backpressure).
- Latency: acceptance edge to out_valid=1 is N+1 cycles (10 at default). Throughput is one word per N+2 cycles.
- Outputs are registered. code is not guaranteed meaningful while out_valid=0; the bench may only check it when out_valid=1.
- Reset asserted in any state returns to the reset values on the next edge. A word in flight is discarded with no out_valid pulse.
- Simultaneous in_valid and rst: reset wins and the word is not captured.
- Arithmetic: the compare/subtract is unsigned at WW+1 bits. residue can never go negative because the subtract is gated by the compare.

Optional Feature:
- Macro: FNS_ENC_ADJ_CHECK_EN.
- Defined:
  - Adds an adjacency checker. Over the positions with en_flag_q=1, taken in index order with disabled positions skipped, code_err=1 if two consecutive enabled positions both have code bit 1.
  - code_err is computed during the ENC pass by tracking the last enabled bit, and is valid with out_valid.
- Undefined: code_err is tied to 0 and the tracking logic is absent.

Test Plan:
- All enabled, weights {1,2,3,5,8,13,21,34,55} (TSV0..8), in_data=20 -> code=9'h02A (bits 5,3,1), overflow=0, code_err=0, out_valid exactly 10 cycles after acceptance.
- en_flag=9'h1FB (TSV2 faulty), weights {1,2,0,3,5,8,13,21,34}, in_data=20 -> code=9'h052 (bits 6,4,1), bit 2 = 0, overflow=0.
- en_flag=9'h007, weights {1,2,3,0,...}, in_data=7 -> code=9'h007, overflow=1; with FNS_ENC_ADJ_CHECK_EN defined code_err=1, without it code_err=0.
- Backpressure: hold out_ready=0 for 5 cycles in DONE -> out_valid and code stable, in_ready=0; a new in_valid is ignored; out_ready=1 -> IDLE, next word accepted one cycle later.
- Change en_flag/weights mid-ENC -> result matches the values captured at acceptance.
- Assert rst at ENC index 4 -> next cycle state IDLE, out_valid=0, in_ready=1, code=0; the following word (in_data=0) gives code=0, overflow=0.
